// File: rtl/counter_seq_checker_pkg.sv
`default_nettype none
// ============================================================================
// Module      : counter_pkg
// Description : Shared types, ring constants and next-value prediction for the
//               3-bit even/odd mode counter and its downstream checker.
//               Even ring (s=1) : 0 -> 2 -> 4 -> 6 -> 0
//               Odd ring  (s=0) : 7 -> 5 -> 3 -> 1 -> 7
//               Off-ring values step by one toward the ring of the active mode.
// Revision    : 1.0 - initial release
// ============================================================================
package counter_pkg;

    typedef enum logic [0:0] {
        INIT  = 1'b0,
        TRACK = 1'b1
    } state_t;

    // First and last members of each ring; a lap is one pass from LAST back to FIRST.
    localparam logic [2:0] c_EVEN_FIRST = 3'd0;
    localparam logic [2:0] c_EVEN_LAST  = 3'd6;
    localparam logic [2:0] c_ODD_FIRST  = 3'd7;
    localparam logic [2:0] c_ODD_LAST   = 3'd1;
    localparam logic [2:0] c_RING_STEP  = 3'd2;

    // Value the counter takes at its next update given the sampled inputs.
    // Arithmetic is modulo 8, so 6+2 wraps to 0 and 1-2 wraps to 7.
    function automatic logic [2:0] nxt_q(input logic cnt_rst,
                                         input logic s,
                                         input logic [2:0] q);
        logic [2:0] r;
        if (s) begin
            r = q[0] ? (q + 3'd1) : (q + c_RING_STEP);
        end else begin
            r = q[0] ? (q - c_RING_STEP) : (q - 3'd1);
        end
        if (cnt_rst) begin
            r = c_EVEN_FIRST;
        end
        return r;
    endfunction

    // True when the prediction made from these inputs closes a ring lap.
    function automatic logic is_wrap(input logic cnt_rst,
                                     input logic s,
                                     input logic [2:0] q);
        return !cnt_rst && ((s && (q == c_EVEN_LAST)) || (!s && (q == c_ODD_LAST)));
    endfunction

endpackage
`default_nettype wire

// File: rtl/counter_seq_checker_if.sv
`default_nettype none
// ============================================================================
// Module      : counter_seq_checker_if
// Description : Bundle of sampled counter signals and checker status outputs.
//               master : counter/board side (drives en, cnt_rst, s, q, err_clr)
//               slave  : checker side (drives expect_q, valid, err, err_sticky,
//                        err_cnt, lap, mode_chg)
//               expect_q carries the predicted counter value; "expect" itself
//               is a reserved word in SystemVerilog.
// Revision    : 1.0 - initial release
// ============================================================================
interface counter_seq_checker_if #(
    parameter int LAP_W = 8,
    parameter int ERR_W = 8
);
    logic             en;
    logic             cnt_rst;
    logic             s;
    logic [2:0]       q;
    logic             err_clr;
    logic [2:0]       expect_q;
    logic             valid;
    logic             err;
    logic             err_sticky;
    logic [ERR_W-1:0] err_cnt;
    logic [LAP_W-1:0] lap;
    logic             mode_chg;

    modport master (
        output en, cnt_rst, s, q, err_clr,
        input  expect_q, valid, err, err_sticky, err_cnt, lap, mode_chg
    );

    modport slave (
        input  en, cnt_rst, s, q, err_clr,
        output expect_q, valid, err, err_sticky, err_cnt, lap, mode_chg
    );
endinterface
`default_nettype wire

// File: rtl/counter_seq_checker_next_q.sv
`default_nettype none
// ============================================================================
// Module      : counter_next_q
// Description : Combinational next-value predictor for the even/odd counter.
//               Kept as its own block so a later model/display stage can reuse
//               exactly the same prediction as the checker.
// Ports       : cnt_rst - counter reset, forces prediction to 0
//               s       - mode (1 even ascending, 0 odd descending)
//               q       - current counter value
//               nxt     - predicted value after the next counter update
//               wrap    - prediction closes a ring lap
// Revision    : 1.0 - initial release
// ============================================================================
module counter_next_q
    import counter_pkg::*;
(
    input  wire logic       cnt_rst,
    input  wire logic       s,
    input  wire logic [2:0] q,
    output logic      [2:0] nxt,
    output logic            wrap
);

    always_comb begin
        nxt  = nxt_q(cnt_rst, s, q);
        wrap = is_wrap(cnt_rst, s, q);
    end

endmodule
`default_nettype wire

// File: rtl/counter_seq_checker.sv
`default_nettype none
// ============================================================================
// Module      : counter_seq_checker
// Description : Monitors the 3-bit even/odd counter. On every enabled rising
//               edge it compares the sampled q against the value predicted at
//               the previous edge, flags and counts mismatches, counts correct
//               laps and reports mode changes. The counter moves on the falling
//               edge, so the inputs sampled here govern the next prediction.
// Ports       : clk  - system clock, rising edge
//               rst  - synchronous reset, active low
//               bus  - counter_seq_checker_if.slave (sampled inputs, status)
// Revision    : 1.0 - initial release
// ============================================================================
module counter_seq_checker
    import counter_pkg::*;
#(
    parameter int LAP_W = 8,
    parameter int ERR_W = 8
)(
    input  wire logic             clk,
    input  wire logic             rst,
    counter_seq_checker_if.slave  bus
);

    localparam logic [ERR_W-1:0] c_ERR_MAX = {ERR_W{1'b1}};

    state_t           r_state;
    logic [2:0]       r_expect;
    logic             r_valid;
    logic             r_err;
    logic             r_sticky;
    logic [ERR_W-1:0] r_err_cnt;
    logic [LAP_W-1:0] r_lap;
    logic             r_mode_chg;
    logic             r_prev_s;
    // Set when r_expect was predicted from the last ring element, so a match
    // on the following sample completes a lap.
    logic             r_wrap_pend;

    logic [2:0]       w_nxt;
    logic             w_wrap;
    logic             w_mismatch;

    counter_next_q u_next (
        .cnt_rst (bus.cnt_rst),
        .s       (bus.s),
        .q       (bus.q),
        .nxt     (w_nxt),
        .wrap    (w_wrap)
    );

    assign w_mismatch = (r_state == TRACK) && (bus.q != r_expect);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= INIT;
            r_expect    <= '0;
            r_valid     <= 1'b0;
            r_err       <= 1'b0;
            r_sticky    <= 1'b0;
            r_err_cnt   <= '0;
            r_lap       <= '0;
            r_mode_chg  <= 1'b0;
            r_prev_s    <= 1'b0;
            r_wrap_pend <= 1'b0;
        end else if (!bus.en) begin
            // Tracking is abandoned; counters, sticky flag and expect hold.
            r_state    <= INIT;
            r_valid    <= 1'b0;
            r_err      <= 1'b0;
            r_mode_chg <= 1'b0;
        end else begin
            r_mode_chg  <= (bus.s != r_prev_s);
            r_prev_s    <= bus.s;

            // Both states resync the prediction to the current sample.
            r_expect    <= w_nxt;
            r_wrap_pend <= w_wrap;
            r_valid     <= 1'b1;
            r_state     <= TRACK;

            if (w_mismatch) begin
                r_err    <= 1'b1;
                r_sticky <= 1'b1;
                // A clear on the same edge as an error leaves exactly this error.
                if (bus.err_clr) begin
                    r_err_cnt <= ERR_W'(1);
                end else if (r_err_cnt != c_ERR_MAX) begin
                    r_err_cnt <= r_err_cnt + ERR_W'(1);
                end
            end else begin
                r_err <= 1'b0;
                if (bus.err_clr) begin
                    r_sticky  <= 1'b0;
                    r_err_cnt <= '0;
                end
            end

            if ((r_state == TRACK) && !w_mismatch && r_wrap_pend) begin
                r_lap <= r_lap + LAP_W'(1);
            end
        end
    end

    assign bus.expect_q   = r_expect;
    assign bus.valid      = r_valid;
    assign bus.err        = r_err;
    assign bus.err_sticky = r_sticky;
    assign bus.err_cnt    = r_err_cnt;
    assign bus.lap        = r_lap;
    assign bus.mode_chg   = r_mode_chg;

endmodule
`default_nettype wire

// File: doc/counter_seq_checker.md
Name: counter_seq_checker

Overview:
- Downstream monitor for the 3-bit even/odd mode counter.
- Samples the counter value `q`, mode `s` and counter reset `cnt_rst` on every enabled rising clock edge (the counter itself updates on the falling edge).
- Predicts the next value and flags mismatches. Counts errors and completed laps.
- Drives the lab board status LEDs and feeds the error/lap display.

Parameters:
- LAP_W, 8, width of lap counter (wraps modulo 2^LAP_W)
- ERR_W, 8, width of error counter (saturates at all-ones)

Ports:
- clk  input  1  system clock; all checker logic on rising edge
- rst  input  1  synchronous reset, active-low
- en  input  1  sample enable; low = checker idle, tracking abandoned
- cnt_rst  input  1  counter's reset (active-high), same domain
- s  input  1  counter mode (1 = even ascending, 0 = odd descending)
- q  input  3  counter output
- err_clr  input  1  clears err_sticky and err_cnt
- expect  output  3  predicted q at next enabled edge
- valid  output  1  expect is meaningful (state TRACK)
- err  output  1  one-cycle pulse: sampled q != expect while TRACK
- err_sticky  output  1  set on any err, held until err_clr or reset
- err_cnt  output  ERR_W  number of errors, saturating
- lap  output  LAP_W  completed correct wraps
- mode_chg  output  1  one-cycle pulse: s differs from previously sampled s

Behaviour:
- Reset (rst=0 at rising edge):
  - All outputs are 0; state is INIT.
  - The stored previous s is 0.
  - Reset overrides en, err_clr and everything else.
- Prediction nxt(cnt_rst,s,q):
  - cnt_rst=1 -> 0.
  - s=1: 0->2, 2->4, 4->6, 6->0; odd q -> q+1 mod 8.
  - s=0: 7->5, 5->3, 3->1, 1->7; even q -> q-1 mod 8 (0->7).
- Inputs s and cnt_rst change only just after a rising edge, so the values sampled at edge k govern the counter's falling edge before edge k+1.
- States: INIT, TRACK.
  - INIT, en=1: expect<=nxt(sampled); valid<=1; no compare; go TRACK.
  - TRACK, en=1:
    - Compare q to expect.
    - Mismatch: err=1; err_sticky<=1; err_cnt+1 (saturating).
    - Always resync: expect<=nxt(sampled current inputs).
    - Stay in TRACK.
  - Any state, en=0: go INIT; valid<=0; err=0; mode_chg=0; counters and sticky hold.
- Lap:
  - Increments in TRACK on a matched sample where the previous expect was produced from 6 with s=1, or from 1 with s=0 (cnt_rst=0).
  - Wraps modulo 2^LAP_W.
- mode_chg:
  - Asserted on an enabled edge where s != stored previous s, in any state.
  - Stored s updates on every enabled edge.
  - First sample after reset compares against 0.
- err_clr:
  - Clears err_sticky and err_cnt.
  - If the same edge detects an error, the error wins: err_cnt=1, err_sticky=1.
- Latency:
  - err and lap update on the rising edge that samples the offending/completing q; err is a registered pulse.
  - expect/valid are registered one edge after the inputs that produced them.

Decomposition:
- Package counter_pkg:
  - state enum {INIT, TRACK}.
  - Constants for the even ring (0,2,4,6) and odd ring (7,5,3,1).
  - Function nxt_q(cnt_rst,s,q).
- One combinational sub-module counter_next_q:
  - Wraps nxt_q.
  - Reusable by a future model/display stage.
- Everything else lives in counter_seq_checker.

Test Plan:
- Reset then en=1, s=1, q sequence 0,2,4,6,0,2 on consecutive edges -> err never pulses; valid=1 from 2nd edge; lap=1 after the edge sampling the 2nd 0.
- s=0, q sequence 7,5,3,1,7,5,3,1,7 -> err=0 throughout; lap=2 at the final sample.
- s=1, q 0,2,5,7 -> err pulses on the edge sampling 5; err_cnt=1; err_sticky=1; after resync expect=6, so 7 errs again (err_cnt=2).
- cnt_rst=1 while q=4 -> expect=0; next sample q=0 -> no error. Toggle s 1->0 -> mode_chg pulses exactly one cycle.
- en low for 3 cycles mid-sequence, then resume with an arbitrary q=3 -> no err on the first resumed sample (INIT); comparing resumes on the next edge.
- Force 256 errors with ERR_W=8 -> err_cnt holds 255. err_clr on the same edge as an error -> err_cnt=1, err_sticky=1. rst=0 with en=1 -> all outputs 0 next edge.
